// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store unit: RV32I width codes,
// FSM states and the accept-time fault check.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Conflicting op bits, width illegal for the op, or misaligned H/W access.
  function automatic logic op_fault(input logic       rd,
                                    input logic       wr,
                                    input logic [2:0] f3,
                                    input logic [1:0] lo);
    logic f;
    f = 1'b0;
    if (rd && wr) begin
      f = 1'b1;
    end else begin
      case (f3)
        F3_B:    f = 1'b0;
        F3_H:    f = lo[0];
        F3_W:    f = |lo;
        F3_BU:   f = wr;
        F3_HU:   f = wr | lo[0];
        default: f = 1'b1;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/grant data-memory port between the load/store unit and data memory.
interface mem_access_unit_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mask;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_mask,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_mask,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/mem_access_unit_load_extract.sv
// Selects the addressed byte/halfword of a read word and sign/zero-extends it.
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   value = {24'h000000, byte_sel};
      F3_H:    value = {{16{half_sel[15]}}, half_sel};
      F3_HU:   value = {16'h0000, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: accepts one op from execute, drives the
// request/grant data-memory port and registers the extended load result.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_mem_valid,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [2:0]         i_funct3,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_store_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_fault,
  mem_access_unit_if.master  dmem,
  output logic [31:0]        data_read_from_dmem
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        fault_q, fault_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] ld_q, ld_d;
  logic [31:0] ld_ext;
  logic        accept;
  logic        accept_fault;

  assign accept       = (state_q == ST_IDLE) && i_mem_valid && (i_mem_read || i_mem_write);
  assign accept_fault = op_fault(i_mem_read, i_mem_write, i_funct3, i_addr[1:0]);

  load_extract u_load_extract (
    .rdata   (dmem.dmem_rdata),
    .funct3  (f3_q),
    .addr_lo (addr_q[1:0]),
    .value   (ld_ext)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      fault_q <= fault_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      ld_q    <= ld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)             state_d = accept_fault ? ST_DONE : ST_REQ;
      ST_REQ:  if (dmem.dmem_gnt)      state_d = we_q ? ST_DONE : ST_WAIT;
      ST_WAIT: if (dmem.dmem_rvalid)   state_d = ST_DONE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Lanes are formed at accept time so the request is stable through any grant delay.
  always_comb begin
    we_d    = we_q;
    fault_d = fault_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    ld_d    = ld_q;
    if (accept) begin
      we_d    = i_mem_write;
      fault_d = accept_fault;
      f3_d    = i_funct3;
      addr_d  = i_addr;
      case (i_funct3[1:0])
        2'b00: begin
          wdata_d = {4{i_store_data[7:0]}};
          mask_d  = 4'b0001 << i_addr[1:0];
        end
        2'b01: begin
          wdata_d = {2{i_store_data[15:0]}};
          mask_d  = i_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_d = i_store_data;
          mask_d  = 4'b1111;
        end
      endcase
    end
    if ((state_q == ST_WAIT) && dmem.dmem_rvalid) begin
      ld_d = ld_ext;
    end
  end

  always_comb begin
    o_busy        = accept || (state_q == ST_REQ) || (state_q == ST_WAIT);
    o_done        = (state_q == ST_DONE);
    o_fault       = (state_q == ST_DONE) && fault_q;
    dmem.dmem_req = (state_q == ST_REQ);
    dmem.dmem_we  = (state_q == ST_REQ) && we_q;
  end

  assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_mask  = mask_q;
  assign data_read_from_dmem = ld_q;

endmodule
